// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential radix-2 restoring divider (seq_divider).
package div_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_FIXUP = 2'd2
   } div_state_e;

   localparam logic [4:0] DIV_OPCODE = 5'b01111;

   // An operand is treated as negative only in signed mode with its MSB set.
   function automatic logic operand_neg(input logic signed_mode, input logic msb);
      return signed_mode & msb;
   endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and result bus between the control unit and seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, signed_mode, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, signed_mode, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate of two values; used for operand magnitudes
// before the iteration and for applying result signs afterwards.
module div_sign_fix #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0] val_a_i,
   input  logic [WIDTH-1:0] val_b_i,
   input  logic             neg_a_i,
   input  logic             neg_b_i,
   output logic [WIDTH-1:0] val_a_o,
   output logic [WIDTH-1:0] val_b_o
);
   // Negating -2^(WIDTH-1) yields the same bit pattern, which is its correct unsigned magnitude.
   assign val_a_o = neg_a_i ? (-val_a_i) : val_a_i;
   assign val_b_o = neg_b_i ? (-val_b_i) : val_b_i;
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, start/done handshake.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iteration (latency 1).
//
//   state   | meaning
//   S_IDLE  | waiting for start; outputs hold last result
//   S_BUSY  | one quotient bit per edge, WIDTH edges
//   S_FIXUP | apply signs / div-by-zero result, pulse done
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic          clock,
   input  logic          clear,
   seq_divider_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic             negq_q, negq_d;
   logic             negr_q, negr_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] quot_out_q, quot_out_d;
   logic [WIDTH-1:0] rem_out_q, rem_out_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic             dvd_neg, dvs_neg;
   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] quo_fix, rem_fix;
   logic [WIDTH:0]   rem_sh, rem_diff;

   assign dvd_neg = operand_neg(bus.signed_mode, bus.dividend[WIDTH-1]);
   assign dvs_neg = operand_neg(bus.signed_mode, bus.divisor[WIDTH-1]);

   div_sign_fix #(.WIDTH(WIDTH)) u_pre (
      .val_a_i (bus.dividend),
      .val_b_i (bus.divisor),
      .neg_a_i (dvd_neg),
      .neg_b_i (dvs_neg),
      .val_a_o (dvd_mag),
      .val_b_o (dvs_mag)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_post (
      .val_a_i (quo_q),
      .val_b_i (rem_q),
      .neg_a_i (negq_q),
      .neg_b_i (negr_q),
      .val_a_o (quo_fix),
      .val_b_o (rem_fix)
   );

   // WIDTH+1-bit partial remainder so the subtract borrow lands in the MSB.
   assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, dvs_q};

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dvs_d      = dvs_q;
      dvd_d      = dvd_q;
      negq_d     = negq_q;
      negr_d     = negr_q;
      zero_d     = zero_q;
      quot_out_d = quot_out_q;
      rem_out_d  = rem_out_q;
      done_d     = 1'b0;
      dbz_d      = dbz_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               dvd_d   = bus.dividend;
               dvs_d   = dvs_mag;
               quo_d   = dvd_mag;
               rem_d   = '0;
               negq_d  = dvd_neg ^ dvs_neg;
               negr_d  = dvd_neg;
               zero_d  = (bus.divisor == '0);
               cnt_d   = CNT_W'(WIDTH);
               dbz_d   = 1'b0;
               state_d = S_BUSY;
`ifdef DIV_ZERO_SHORTCUT_EN
               if (bus.divisor == '0) state_d = S_FIXUP;
`endif
            end
         end
         S_BUSY: begin
            if (!rem_diff[WIDTH]) begin
               rem_d = rem_diff[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_sh[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
         end
         S_FIXUP: begin
            if (zero_q) begin
               quot_out_d = '1;
               rem_out_d  = dvd_q;
               dbz_d      = 1'b1;
            end else begin
               quot_out_d = quo_fix;
               rem_out_d  = rem_fix;
               dbz_d      = 1'b0;
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         dvs_q      <= '0;
         dvd_q      <= '0;
         negq_q     <= 1'b0;
         negr_q     <= 1'b0;
         zero_q     <= 1'b0;
         quot_out_q <= '0;
         rem_out_q  <= '0;
         done_q     <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dvs_q      <= dvs_d;
         dvd_q      <= dvd_d;
         negq_q     <= negq_d;
         negr_q     <= negr_d;
         zero_q     <= zero_d;
         quot_out_q <= quot_out_d;
         rem_out_q  <= rem_out_d;
         done_q     <= done_d;
         dbz_q      <= dbz_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.quotient    = quot_out_q;
   assign bus.remainder   = rem_out_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed cases plus random
// operands against an arithmetic reference model.
module tb_seq_divider;
   localparam int W = 32;

   logic clock;
   logic clear;
   int   n_chk;
   int   n_fail;
   logic [W-1:0] prev_q, prev_r;

   seq_divider_if #(.WIDTH(W)) dif ();

   seq_divider #(.WIDTH(W)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (dif)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain language-level division, truncating toward zero.
   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                                 output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
      int sa, sb;
      sa = a;
      sb = b;
      z  = (b == 0);
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sm) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = '0;
         end else begin
            q = sa / sb;
            r = sa % sb;
         end
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   function automatic int exp_lat(input logic [W-1:0] b);
`ifdef DIV_ZERO_SHORTCUT_EN
      if (b == 0) return 1;
`endif
      return W + 1;
   endfunction

   // Called at #1 after an edge (or time 0 after reset release); returns at #1
   // after the result edge with done expected high.
   task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input bit inject);
      int edges;
      dif.dividend    = a;
      dif.divisor     = b;
      dif.signed_mode = sm;
      dif.start       = 1'b1;
      @(posedge clock); #1;
      dif.start = 1'b0;
      chk({tag, "_busy_acc"}, dif.busy, 1'b1);
      chk({tag, "_done_acc"}, dif.done, 1'b0);
      edges = 0;
      while (!dif.done && edges < 100) begin
         @(posedge clock); #1;
         edges++;
         if (inject && (edges == 4 || edges == 19)) begin
            dif.start       = 1'b1;
            dif.dividend    = $urandom;
            dif.divisor     = $urandom;
            dif.signed_mode = ~sm;
         end
         if (inject && (edges == 5 || edges == 20)) dif.start = 1'b0;
         if (edges == 10) begin
            chk({tag, "_hold_q"}, dif.quotient, prev_q);
            chk({tag, "_hold_r"}, dif.remainder, prev_r);
         end
      end
      chk({tag, "_latency"}, edges, exp_lat(b));
      chk({tag, "_done"}, dif.done, 1'b1);
      chk({tag, "_busy_res"}, dif.busy, 1'b0);
      chk({tag, "_q"}, dif.quotient, eq);
      chk({tag, "_r"}, dif.remainder, er);
      chk({tag, "_dbz"}, dif.div_by_zero, ez);
      prev_q = eq;
      prev_r = er;
   endtask

   task automatic post_done(input string tag, input logic ez);
      @(posedge clock); #1;
      chk({tag, "_done_pulse"}, dif.done, 1'b0);
      chk({tag, "_q_held"}, dif.quotient, prev_q);
      chk({tag, "_dbz_held"}, dif.div_by_zero, ez);
   endtask

   initial begin
      logic [W-1:0] a, b, eq, er;
      logic sm, ez;
      n_chk  = 0;
      n_fail = 0;
      prev_q = '0;
      prev_r = '0;
      dif.start       = 1'b0;
      dif.signed_mode = 1'b0;
      dif.dividend    = '0;
      dif.divisor     = '0;
      clear = 1'b0;
      #12;
      chk("rst_busy", dif.busy, 1'b0);
      chk("rst_done", dif.done, 1'b0);
      chk("rst_q", dif.quotient, 0);
      chk("rst_r", dif.remainder, 0);
      chk("rst_dbz", dif.div_by_zero, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      @(posedge clock); #1;

      do_op("sdiv", 32'h0000_0FF5, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FAAF, 32'h0000_0002, 1'b0, 1'b0);
      post_done("sdiv", 1'b0);
      do_op("udiv", 32'h0000_0FF5, 32'hFFFF_FFFD, 1'b0, 32'h0, 32'h0000_0FF5, 1'b0, 1'b0);
      post_done("udiv", 1'b0);
      do_op("udiv40", 32'h28, 32'h5, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
      post_done("udiv40", 1'b0);
      do_op("trunc", 32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      post_done("trunc", 1'b0);
      do_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0, 1'b0);
      post_done("ovf", 1'b0);
      do_op("dz", 32'h28, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h28, 1'b1, 1'b0);
      post_done("dz", 1'b1);
      do_op("dzs", 32'hFFFF_FFF0, 32'h0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1, 1'b0);
      post_done("dzs", 1'b1);

      // Starts at N+5 and N+20 ignored, then back-to-back start on the edge after done.
      do_op("hs", 32'd1000, 32'd7, 1'b0, 32'd142, 32'd6, 1'b0, 1'b1);
      do_op("b2b", 32'hFFFF_FF9C, 32'd9, 1'b1, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 1'b0, 1'b0);
      post_done("b2b", 1'b0);

      // Asynchronous clear in the middle of an operation.
      dif.dividend    = 32'hFFFF_FFFF;
      dif.divisor     = 32'd3;
      dif.signed_mode = 1'b0;
      dif.start       = 1'b1;
      @(posedge clock); #1;
      dif.start = 1'b0;
      repeat (10) @(posedge clock);
      #2;
      clear = 1'b0;
      #1;
      chk("clr_busy", dif.busy, 1'b0);
      chk("clr_done", dif.done, 1'b0);
      chk("clr_q", dif.quotient, 0);
      chk("clr_r", dif.remainder, 0);
      chk("clr_dbz", dif.div_by_zero, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      chk("clr_no_done", dif.done, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      prev_q = '0;
      prev_r = '0;
      @(posedge clock); #1;
      do_op("after_clr", 32'h28, 32'h5, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0);
      post_done("after_clr", 1'b0);

      for (int i = 0; i < 24; i++) begin
         a  = $urandom;
         sm = $urandom_range(0, 1);
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = $urandom_range(1, 15);
            2:       b = -$urandom_range(1, 15);
            3:       begin a = 32'h8000_0000; b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : $urandom; end
            default: b = $urandom >> $urandom_range(0, 30);
         endcase
         model(a, b, sm, eq, er, ez);
         do_op("rnd", a, b, sm, eq, er, ez, (b != 0) && ($urandom_range(0, 3) == 0));
         post_done("rnd", ez);
         repeat ($urandom_range(0, 2)) @(posedge clock);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
